// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared definitions for the scoreboard controller.
//   - state_e    : command FSM state encoding
//   - CNT_W      : width of every counter in the controller
//   - *_DEF      : default parameter values for scoreboard_ctrl / btn_debounce
package scoreboard_pkg;

  localparam int CNT_W = 8;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int ERASE_CYCLES_DEF    = 6;
  localparam int REPEAT_CYCLES_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ERASE    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: cleans up one raw push-button.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   btn_i   : raw asynchronous button, active-high
//   level_o : debounced button level
//   rise_o  : one-cycle strobe, high in the first cycle level_o reads 1
// The debounced level only follows the synchronised input after it has
// disagreed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
  import scoreboard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_d, sync1_q;
  logic             sync2_d, sync2_q;
  logic             level_d, level_q;
  logic             rise_d,  rise_q;
  logic [CNT_W-1:0] cnt_d,   cnt_q;

  always_comb begin
    // Stage: two-flop synchroniser
    sync1_d = btn_i;
    sync2_d = sync1_q;
    // Stage: debounce counter; any agreement restarts the count
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Stage: rising-edge strobe, aligned with the new level
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: turns three bouncing buttons into scoreboard commands.
//   clk         : system clock
//   rst         : asynchronous active-low reset (aborts an erase in progress)
//   btn_inc_i   : raw increment button
//   btn_dec_i   : raw decrement button
//   btn_erase_i : raw erase button
//   inc_o       : one-cycle increment pulse
//   dec_o       : one-cycle decrement pulse
//   erase_o     : erase level, high for exactly ERASE_CYCLES cycles
//   busy_o      : high while the command FSM is outside IDLE
// Optional build macro SCOREBOARD_CTRL_AUTO_REPEAT_EN: a held inc or dec
// button re-issues its pulse every REPEAT_CYCLES cycles while in IDLE.
module scoreboard_ctrl
  import scoreboard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ERASE_CYCLES    = ERASE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc_i,
  input  logic btn_dec_i,
  input  logic btn_erase_i,
  output logic inc_o,
  output logic dec_o,
  output logic erase_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES);
  localparam logic [CNT_W-1:0] ECNT_LAST  = CNT_W'(1);

  logic             lvl_inc, lvl_dec, lvl_erase;
  logic             rise_inc, rise_dec, rise_erase;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] ecnt_d, ecnt_q;
  logic             inc_d, inc_q;
  logic             dec_d, dec_q;
  logic             rep_fire;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst(rst), .btn_i(btn_inc_i), .level_o(lvl_inc), .rise_o(rise_inc)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk(clk), .rst(rst), .btn_i(btn_dec_i), .level_o(lvl_dec), .rise_o(rise_dec)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_erase (
    .clk(clk), .rst(rst), .btn_i(btn_erase_i), .level_o(lvl_erase), .rise_o(rise_erase)
  );

`ifdef SCOREBOARD_CTRL_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_d, rep_q;

  // The counter is held at zero in the cycle of the initial pulse so the
  // first repeat lands exactly REPEAT_CYCLES after it.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if ((state_q == ST_IDLE) && (lvl_inc ^ lvl_dec) && !(rise_inc || rise_dec)) begin
      if (rep_q == REP_LAST) begin
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  logic unused_repeat;
  assign rep_fire      = 1'b0;
  assign unused_repeat = (REPEAT_CYCLES != 0) ^ lvl_inc ^ lvl_dec;
`endif

  always_comb begin
    state_d = state_q;
    ecnt_d  = ecnt_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_erase) begin
          state_d = ST_ERASE;
          ecnt_d  = ERASE_LOAD;
        end else if (rise_inc ^ rise_dec) begin
          // Simultaneous inc and dec cancel each other.
          inc_d = rise_inc;
          dec_d = rise_dec;
        end else if (rep_fire) begin
          inc_d = lvl_inc;
          dec_d = lvl_dec;
        end
      end
      ST_ERASE: begin
        ecnt_d = ecnt_q - 1'b1;
        if (ecnt_q == ECNT_LAST) begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        // Hold off until the button is released so it cannot retrigger.
        if (!lvl_erase) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ecnt_q  <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ecnt_q  <= ecnt_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign inc_o   = inc_q;
  assign dec_o   = dec_q;
  assign erase_o = (state_q == ST_ERASE);
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: doc/scoreboard_ctrl.md
Name: scoreboard_ctrl

Overview:
- Controller side of the scoreboard's inc/dec/erase command interface.
- Turns three raw, bouncing push-buttons into clean commands for the scoreboard:
  - single-cycle inc/dec pulses;
  - a fixed-length held erase.
- Sits between the board pins and the scoreboard in the ScoreboardAndController top level.
- Stages: synchronise → debounce → edge-detect → command FSM.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before a debounced level changes (1..255).
- ERASE_CYCLES, 6, number of cycles erase_o is held high per erase command (1..255).
- REPEAT_CYCLES, 16, auto-repeat period in cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_inc_i  input  1  raw increment button, asynchronous, active-high.
- btn_dec_i  input  1  raw decrement button, asynchronous, active-high.
- btn_erase_i  input  1  raw erase button, asynchronous, active-high.
- inc_o  output  1  one-cycle increment pulse to the scoreboard.
- dec_o  output  1  one-cycle decrement pulse to the scoreboard.
- erase_o  output  1  erase level to the scoreboard, high for exactly ERASE_CYCLES cycles.
- busy_o  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (rst low, any time, asynchronous):
  - inc_o, dec_o, erase_o, busy_o = 0.
  - Sync flops, debounced levels and counters = 0; FSM = IDLE.
  - An erase in progress is aborted.
- Synchroniser: two flops per button.
- Debouncer, per button:
  - The counter increments while the synced value differs from the debounced value.
  - It clears whenever they agree.
  - When the count reaches DEBOUNCE_CYCLES, the debounced value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Edge detect: a rise_x strobe is generated on each 0→1 transition of a debounced level. Falling edges produce nothing.
- Outputs are registered. Latency from the first rising edge that samples a clean press to inc_o high = 2 + DEBOUNCE_CYCLES + 1 cycles (7 at defaults).
- FSM states:
  - IDLE:
    - rise_erase → ERASE, erase counter loaded with ERASE_CYCLES.
    - Otherwise, rise_inc alone → inc_o = 1 for one cycle.
    - rise_dec alone → dec_o = 1 for one cycle.
  - ERASE: erase_o = 1; the counter decrements each cycle. When it reaches 1, next state is WAIT_REL (erase_o stays high exactly ERASE_CYCLES cycles).
  - WAIT_REL: erase_o = 0; remain until the debounced erase level is 0, then → IDLE. This stops a held erase button from retriggering.
- Simultaneous and blocked events:
  - rise_erase together with rise_inc/rise_dec: erase wins, inc/dec are dropped.
  - rise_inc and rise_dec in the same cycle: both dropped, no pulse.
  - rise_inc/rise_dec outside IDLE: dropped, not queued.
- inc_o, dec_o and erase_o are never high in the same cycle.
- A button held indefinitely produces exactly one pulse (without the optional feature).

Optional Feature:
- Macro: SCOREBOARD_CTRL_AUTO_REPEAT_EN.
- Defined:
  - While in IDLE with exactly one of debounced inc or dec held high, a repeat counter runs.
  - A further pulse on that output is issued every REPEAT_CYCLES cycles after the initial pulse.
  - Release, both buttons held, or leaving IDLE clears the counter.
- Undefined: no repeat logic is present; one pulse per press.

Decomposition:
- Package scoreboard_pkg holds:
  - the FSM state encoding (IDLE=2'd0, ERASE=2'd1, WAIT_REL=2'd2);
  - counter width constant CNT_W = 8;
  - default parameter values.
- Sub-module btn_debounce (sync + debounce + rise strobe; parameter DEBOUNCE_CYCLES), instantiated three times.
- The FSM stays in the top module.

Test Plan:
- Reset mid-erase: rst low during ERASE → erase_o, busy_o drop to 0 immediately (asynchronously); FSM = IDLE after release.
- Clean inc press: btn_inc_i held 20 cycles → exactly one inc_o pulse, 7 cycles after the first sampling edge; dec_o and erase_o stay 0.
- Bounce: btn_dec_i toggles with 1–3 cycle glitches, then stays high → exactly one dec_o pulse. A standalone 3-cycle glitch → none.
- Erase: btn_erase_i held 30 cycles → erase_o high for exactly 6 cycles, then WAIT_REL until release; busy_o high throughout; no second erase.
- Conflicts:
  - inc and dec pressed on the same edge → no pulses.
  - inc pressed during ERASE → no inc_o.
  - erase and inc rising together → erase only.
- Auto-repeat (with SCOREBOARD_CTRL_AUTO_REPEAT_EN): btn_inc_i held 60 cycles → initial pulse plus pulses every 16 cycles; without the macro → single pulse.
